sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_mem.sv | 21 ++
 rtl/sync_fifo_param.sv | 69 ++++++
 tb/tb_sync_fifo_param.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and a constant clog2 helper for the FIFO
package fifo_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_AF_LVL = DEF_DEPTH - 2;
  localparam int DEF_AE_LVL = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_W storage with one synchronous write and one synchronous read port
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic              clk,
  input  logic              wr,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  // read sees the old word when the same slot is written in the same cycle
  always_ff @(posedge clk) begin
    if (wr) mem[wr_addr] <= wr_data;
    if (rd) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy flags and sticky overflow/underflow
module sync_fifo_param import fifo_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = DEF_AE_LVL,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C = CNT_W'(AF_LVL);
  localparam logic [CNT_W-1:0] AE_C = CNT_W'(AE_LVL);
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic wr_acc, rd_acc, has_data;
  assign full = count == FULL_C;
  assign empty = count == '0;
  assign almost_full = count >= AF_C;
  assign almost_empty = count <= AE_C;
  assign wr_acc = wr_en & (~full | rd_en);
  assign rd_acc = rd_en & ~empty;
  // memory keeps its last read word after reset, so data_out is masked until the first read
  assign data_out = has_data ? rd_data : '0;
  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk(clk),
    .wr(wr_acc & ~rst),
    .wr_addr(wr_ptr),
    .wr_data(data_in),
    .rd(rd_acc & ~rst),
    .rd_addr(rd_ptr),
    .rd_data(rd_data)
  );
  // pointers, occupancy, read strobe and sticky error flags (set wins over clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rd_valid <= 1'b0;
      has_data <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      if (rd_acc) has_data <= 1'b1;
      count <= count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      rd_valid <= rd_acc;
      overflow <= (wr_en & full & ~rd_en) | (overflow & ~err_clr);
      underflow <= (rd_en & empty) | (underflow & ~err_clr);
    end
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed table plus corner-case sequences for sync_fifo_param
module tb_sync_fifo_param;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] data_in = '0, data_out;
  logic rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {
    logic wr; logic rd; logic clr; logic [7:0] din;
    logic [4:0] cnt; logic [7:0] dout; logic rv; logic ov; logic uf;
  } vec_t;
  vec_t tbl [11];
  logic [7:0] q [$];
  logic [7:0] exp_d;
  int mcnt;
  sync_fifo_param dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .err_clr(err_clr), .data_out(data_out), .rd_valid(rd_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en = w;
    data_in = d;
    rd_en = r;
    err_clr = c;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    err_clr = 1'b0;
  endtask
  task automatic flags(input string nm, input int c);
    chk({nm, "_count"}, 64'(count), 64'(c));
    chk({nm, "_full"}, 64'(full), 64'(c == 16));
    chk({nm, "_empty"}, 64'(empty), 64'(c == 0));
    chk({nm, "_afull"}, 64'(almost_full), 64'(c >= 14));
    chk({nm, "_aempty"}, 64'(almost_empty), 64'(c <= 2));
  endtask
  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'hA1, 5'd1, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'hA2, 5'd2, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 8'hA1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 8'hA1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 8'hA2, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 8'hA2, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 8'hA2, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h33, 5'd1, 8'hA2, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h00, 5'd0, 8'h33, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h00, 5'd0, 8'h33, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 8'h33, 1'b0, 1'b0, 1'b0};
    #2;
    flags("rst", 0);
    chk("rst_dout", 64'(data_out), 64'h0);
    chk("rst_rv", 64'(rd_valid), 64'h0);
    chk("rst_ov", 64'(overflow), 64'h0);
    chk("rst_uf", 64'(underflow), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].wr, tbl[i].din, tbl[i].rd, tbl[i].clr);
      flags($sformatf("tbl%0d", i), int'(tbl[i].cnt));
      chk($sformatf("tbl%0d_dout", i), 64'(data_out), 64'(tbl[i].dout));
      chk($sformatf("tbl%0d_rv", i), 64'(rd_valid), 64'(tbl[i].rv));
      chk($sformatf("tbl%0d_ov", i), 64'(overflow), 64'(tbl[i].ov));
      chk($sformatf("tbl%0d_uf", i), 64'(underflow), 64'(tbl[i].uf));
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      flags($sformatf("fill%0d", i), i);
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk($sformatf("drain%0d_dout", i), 64'(data_out), 64'(i));
      chk($sformatf("drain%0d_rv", i), 64'(rd_valid), 64'h1);
      flags($sformatf("drain%0d", i), 16 - i);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle_hold_dout", 64'(data_out), 64'h10);
    chk("idle_rv", 64'(rd_valid), 64'h0);
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_set", 64'(overflow), 64'h1);
    flags("ovf", 16);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 64'(overflow), 64'h0);
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    chk("ovf_set_prio", 64'(overflow), 64'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr2", 64'(overflow), 64'h0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("simul_dout", 64'(data_out), 64'h01);
    chk("simul_rv", 64'(rd_valid), 64'h1);
    chk("simul_ov", 64'(overflow), 64'h0);
    flags("simul", 16);
    for (int i = 2; i <= 17; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk($sformatf("post_simul%0d", i), 64'(data_out), 64'(i == 17 ? 8'h55 : 8'(i)));
    end
    flags("post_simul", 0);
    q.delete();
    mcnt = 0;
    for (int k = 0; k < 70; k++) begin
      logic w, r, wa, ra;
      w = (k < 60) && (k % 3 != 0);
      r = (k % 2 == 0) || (k >= 50);
      wa = w && (mcnt != 16 || r);
      ra = r && mcnt != 0;
      step(w, 8'(8'h80 + k), r, 1'b0);
      if (ra) begin
        exp_d = q.pop_front();
        chk($sformatf("ilv%0d_dout", k), 64'(data_out), 64'(exp_d));
      end
      if (wa) q.push_back(8'(8'h80 + k));
      mcnt = mcnt + int'(wa) - int'(ra);
      chk($sformatf("ilv%0d_rv", k), 64'(rd_valid), 64'(ra));
      chk($sformatf("ilv%0d_count", k), 64'(count), 64'(mcnt));
      chk($sformatf("ilv%0d_le16", k), 64'(count <= 5'd16), 64'h1);
    end
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd7);
    chk("pre_rst_dout", 64'(data_out), 64'hC0);
    #3;
    rst = 1'b1;
    #1;
    flags("async_rst", 0);
    chk("async_rst_dout", 64'(data_out), 64'h0);
    chk("async_rst_rv", 64'(rd_valid), 64'h0);
    wr_en = 1'b1;
    rd_en = 1'b1;
    data_in = 8'hEE;
    @(posedge clk);
    #1;
    flags("rst_ignore", 0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst = 1'b0;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    flags("post_rst_wr", 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_dout", 64'(data_out), 64'h77);
    flags("post_rst_rd", 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
